// File: rtl/satarx_deframer.sv
// rtl/satarx_deframer.sv - SATA receive deframer: strips SOF/EOF primitives and emits payload words with TLAST
// Optional macro SATARX_CRC_STRIP_EN: hold two pending words and drop the trailing CRC word on EOF.
module satarx_deframer #(
   parameter logic [32:0] P_SOF        = 33'h1_7cb5_3737,
   parameter logic [32:0] P_EOF        = 33'h1_7cb5_d5d5,
   parameter logic        OPT_LOWPOWER = 1'b0
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESETN,
   input  logic        S_AXIS_TVALID,
   output logic        S_AXIS_TREADY,
   input  logic [32:0] S_AXIS_TDATA,
   output logic        M_AXIS_TVALID,
   input  logic        M_AXIS_TREADY,
   output logic [31:0] M_AXIS_TDATA,
   output logic        M_AXIS_TLAST,
   output logic        o_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FIRST = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pend0;
   logic        r_mvalid;
   logic [31:0] r_mdata;
   logic        r_mlast;
   logic        r_err;
`ifdef SATARX_CRC_STRIP_EN
   logic [31:0] r_pend1;
   logic        r_two;
   logic [31:0] w_pend1_nx;
   logic        w_two_nx;
`endif

   logic        w_sready;
   logic        w_accept;
   logic        w_prim;
   logic        w_sof;
   logic        w_eof;
   logic [1:0]  w_state_nx;
   logic [31:0] w_pend0_nx;
   logic        w_load;
   logic [31:0] w_ld_data;
   logic        w_ld_last;
   logic        w_err;

   assign w_sready = !r_mvalid || M_AXIS_TREADY;
   assign w_accept = S_AXIS_TVALID && w_sready;
   assign w_prim   = S_AXIS_TDATA[32];
   assign w_sof    = (S_AXIS_TDATA == P_SOF);
   assign w_eof    = (S_AXIS_TDATA == P_EOF);

   always_comb begin
      w_state_nx = r_state;
      w_pend0_nx = r_pend0;
      w_load     = 1'b0;
      w_ld_data  = r_pend0;
      w_ld_last  = 1'b0;
      w_err      = 1'b0;
`ifdef SATARX_CRC_STRIP_EN
      w_pend1_nx = r_pend1;
      w_two_nx   = r_two;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_prim)
               w_err = 1'b1;
            else if (w_accept && w_sof)
               w_state_nx = S_FIRST;
         end
         S_FIRST: begin
            if (w_accept && !w_prim) begin
               w_pend0_nx = S_AXIS_TDATA[31:0];
`ifdef SATARX_CRC_STRIP_EN
               w_two_nx   = 1'b0;
`endif
               w_state_nx = S_DATA;
            end else if (w_accept && w_sof) begin
               w_err = 1'b1;
            end else if (w_accept && w_eof) begin
               w_err      = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         S_DATA: begin
`ifdef SATARX_CRC_STRIP_EN
            // The newest word may be the CRC, so output trails input by two words.
            if (w_accept && !w_prim) begin
               if (r_two) begin
                  w_load     = 1'b1;
                  w_pend0_nx = r_pend1;
               end
               w_pend1_nx = S_AXIS_TDATA[31:0];
               w_two_nx   = 1'b1;
            end else if (w_accept && w_sof) begin
               w_load     = r_two;
               w_ld_last  = 1'b1;
               w_err      = 1'b1;
               w_two_nx   = 1'b0;
               w_state_nx = S_FIRST;
            end else if (w_accept && w_eof) begin
               w_load     = r_two;
               w_ld_last  = 1'b1;
               w_err      = !r_two;
               w_two_nx   = 1'b0;
               w_state_nx = S_IDLE;
            end
`else
            if (w_accept && !w_prim) begin
               w_load     = 1'b1;
               w_pend0_nx = S_AXIS_TDATA[31:0];
            end else if (w_accept && w_sof) begin
               w_load     = 1'b1;
               w_ld_last  = 1'b1;
               w_err      = 1'b1;
               w_state_nx = S_FIRST;
            end else if (w_accept && w_eof) begin
               w_load     = 1'b1;
               w_ld_last  = 1'b1;
               w_state_nx = S_IDLE;
            end
`endif
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state  <= S_IDLE;
         r_pend0  <= 32'd0;
         r_mvalid <= 1'b0;
         r_mdata  <= 32'd0;
         r_mlast  <= 1'b0;
         r_err    <= 1'b0;
`ifdef SATARX_CRC_STRIP_EN
         r_pend1  <= 32'd0;
         r_two    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_pend0 <= w_pend0_nx;
         r_err   <= w_err;
`ifdef SATARX_CRC_STRIP_EN
         r_pend1 <= w_pend1_nx;
         r_two   <= w_two_nx;
`endif
         if (w_load) begin
            r_mvalid <= 1'b1;
            r_mdata  <= w_ld_data;
            r_mlast  <= w_ld_last;
         end else if (M_AXIS_TREADY) begin
            r_mvalid <= 1'b0;
            if (OPT_LOWPOWER) begin
               r_mdata <= 32'd0;
               r_mlast <= 1'b0;
            end
         end
      end
   end

   assign S_AXIS_TREADY = w_sready;
   assign M_AXIS_TVALID = r_mvalid;
   assign M_AXIS_TDATA  = r_mdata;
   assign M_AXIS_TLAST  = r_mlast;
   assign o_err         = r_err;

endmodule

// File: tb/tb_satarx_deframer.sv
// tb/tb_satarx_deframer.sv - self-checking bench for satarx_deframer (frame-level model, random plus directed)
module tb_satarx_deframer;

   localparam logic [32:0] SOF   = 33'h1_7cb5_3737;
   localparam logic [32:0] EOF   = 33'h1_7cb5_d5d5;
   localparam logic [32:0] HOLD  = 33'h1_7caa_d5d5;
   localparam logic [32:0] HOLDA = 33'h1_7caa_9595;
`ifdef SATARX_CRC_STRIP_EN
   localparam int K = 2;
`else
   localparam int K = 1;
`endif

   typedef struct {
      logic [31:0] d;
      logic        l;
   } ow_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [32:0] s_tdata = 33'd0;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic        o_err;

   int total = 0;
   int bad = 0;
   int err_seen = 0;
   int stall_seen = 0;
   bit acc = 1'b0;

   bit          in_frame = 1'b0;
   logic [31:0] fw[$];
   ow_t         expq[$];
   ow_t         obs[$];
   bit          exp_err = 1'b0;

   satarx_deframer dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXIS_TVALID (s_tvalid),
      .S_AXIS_TREADY (s_tready),
      .S_AXIS_TDATA  (s_tdata),
      .M_AXIS_TVALID (m_tvalid),
      .M_AXIS_TREADY (m_tready),
      .M_AXIS_TDATA  (m_tdata),
      .M_AXIS_TLAST  (m_tlast),
      .o_err         (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endfunction

   // Frame-level reference: a frame's words are emitted in order, all but the
   // last K held back; the terminating primitive releases the oldest remaining.
   function automatic void model_accept(logic [32:0] w);
      ow_t o;
      if (!w[32]) begin
         if (!in_frame) exp_err = 1'b1;
         else begin
            fw.push_back(w[31:0]);
            if (fw.size() > K) begin
               o.d = fw.pop_front();
               o.l = 1'b0;
               expq.push_back(o);
            end
         end
      end else if (w == SOF) begin
         if (in_frame) begin
            exp_err = 1'b1;
            if (fw.size() == K) begin
               o.d = fw[0];
               o.l = 1'b1;
               expq.push_back(o);
            end
         end
         in_frame = 1'b1;
         fw.delete();
      end else if (w == EOF) begin
         if (in_frame) begin
            if (fw.size() < K) exp_err = 1'b1;
            else begin
               o.d = fw[0];
               o.l = 1'b1;
               expq.push_back(o);
            end
         end
         in_frame = 1'b0;
         fw.delete();
      end
   endfunction

   function automatic void model_reset();
      in_frame = 1'b0;
      fw.delete();
      expq.delete();
      exp_err = 1'b0;
   endfunction

   // One clock: inputs are already set; called and returns at a falling edge.
   task automatic tick();
      ow_t o;
      #1;
      chk("s_tready", {31'd0, s_tready}, {31'd0, (!m_tvalid || m_tready)});
      if (!s_tready) stall_seen++;
      acc = s_tvalid && s_tready;
      if (m_tvalid && m_tready) begin
         if (expq.size() > 0) void'(expq.pop_front());
         o.d = m_tdata;
         o.l = m_tlast;
         obs.push_back(o);
      end
      exp_err = 1'b0;
      if (acc) model_accept(s_tdata);
      @(posedge clk);
      @(negedge clk);
      chk("o_err", {31'd0, o_err}, {31'd0, exp_err});
      if (o_err === 1'b1) err_seen++;
      chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, (expq.size() > 0)});
      if (expq.size() > 0) begin
         chk("m_tdata", m_tdata, expq[0].d);
         chk("m_tlast", {31'd0, m_tlast}, {31'd0, expq[0].l});
      end
   endtask

   task automatic send(logic [32:0] w);
      bit done = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = w;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (acc) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic obs_chk(string n, int idx, logic [31:0] d, logic l);
      if (idx >= obs.size()) chk({n, "_missing"}, obs.size(), idx + 1);
      else begin
         chk({n, "_data"}, obs[idx].d, d);
         chk({n, "_last"}, {31'd0, obs[idx].l}, {31'd0, l});
      end
   endtask

   task automatic begin_case();
      m_tready = 1'b1;
      obs.delete();
      err_seen = 0;
      stall_seen = 0;
   endtask

   function automatic logic [32:0] rand_word();
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) return SOF;
      if (r < 30) return EOF;
      if (r < 45) return {17'h1_7caa, 16'($urandom)};
      return {1'b0, 32'($urandom)};
   endfunction

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      rst_n = 1'b1;
      idle(2);

      begin_case();
      send(SOF); send(33'h11); send(33'h22); send(33'h33); send(EOF);
      idle(3);
`ifdef SATARX_CRC_STRIP_EN
      chk("basic_cnt", obs.size(), 2);
      obs_chk("basic0", 0, 32'h11, 1'b0);
      obs_chk("basic1", 1, 32'h22, 1'b1);
`else
      chk("basic_cnt", obs.size(), 3);
      obs_chk("basic0", 0, 32'h11, 1'b0);
      obs_chk("basic1", 1, 32'h22, 1'b0);
      obs_chk("basic2", 2, 32'h33, 1'b1);
`endif
      chk("basic_err", err_seen, 0);

      begin_case();
      send(SOF); send(33'hA); send(HOLD); send(HOLD); send(33'hB); send(HOLDA); send(EOF);
      idle(3);
`ifdef SATARX_CRC_STRIP_EN
      chk("hold_cnt", obs.size(), 1);
      obs_chk("hold0", 0, 32'hA, 1'b1);
`else
      chk("hold_cnt", obs.size(), 2);
      obs_chk("hold0", 0, 32'hA, 1'b0);
      obs_chk("hold1", 1, 32'hB, 1'b1);
`endif
      chk("hold_err", err_seen, 0);

      begin_case();
      send(33'h55); send(SOF); send(EOF);
      idle(3);
      chk("idle_err", err_seen, 2);
      chk("idle_cnt", obs.size(), 0);

      begin_case();
      send(SOF); send(33'h1); send(33'h2); send(SOF); send(33'h3); send(EOF);
      idle(3);
`ifdef SATARX_CRC_STRIP_EN
      chk("resof_cnt", obs.size(), 1);
      obs_chk("resof0", 0, 32'h1, 1'b1);
      chk("resof_err", err_seen, 2);
`else
      chk("resof_cnt", obs.size(), 3);
      obs_chk("resof0", 0, 32'h1, 1'b0);
      obs_chk("resof1", 1, 32'h2, 1'b1);
      obs_chk("resof2", 2, 32'h3, 1'b1);
      chk("resof_err", err_seen, 1);
`endif

      begin_case();
      send(SOF); send(33'h1); send(33'h2);
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 33'h3;
      acc = 1'b0;
      begin
         bit got3 = 1'b0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (acc) begin
               got3 = 1'b1;
               s_tvalid = 1'b0;
            end
         end
         m_tready = 1'b1;
         if (!got3) send(33'h3);
      end
      s_tvalid = 1'b0;
      send(EOF);
      idle(3);
      chk("stall_seen", {31'd0, (stall_seen > 0)}, 32'd1);
`ifdef SATARX_CRC_STRIP_EN
      chk("stall_cnt", obs.size(), 2);
      obs_chk("stall0", 0, 32'h1, 1'b0);
      obs_chk("stall1", 1, 32'h2, 1'b1);
`else
      chk("stall_cnt", obs.size(), 3);
      obs_chk("stall0", 0, 32'h1, 1'b0);
      obs_chk("stall1", 1, 32'h2, 1'b0);
      obs_chk("stall2", 2, 32'h3, 1'b1);
`endif

      begin_case();
      send(SOF); send(33'h7);
      rst_n = 1'b0;
      #1;
      chk("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("arst_tdata", m_tdata, 32'd0);
      chk("arst_tlast", {31'd0, m_tlast}, 32'd0);
      chk("arst_err", {31'd0, o_err}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      obs.delete();
      send(SOF); send(33'h8);
`ifdef SATARX_CRC_STRIP_EN
      send(33'h9);
`endif
      send(EOF);
      idle(3);
      chk("arst_cnt", obs.size(), 1);
      obs_chk("arst0", 0, 32'h8, 1'b1);

      acc = 1'b0;
      s_tvalid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!s_tvalid || acc) begin
            s_tvalid = ($urandom_range(0, 4) != 0);
            s_tdata  = rand_word();
         end
         m_tready = ($urandom_range(0, 9) < 7);
         tick();
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      send(EOF);
      idle(4);
      chk("final_drain", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
